layer_out_streamer: RTL and testbench
=====================================

# layer_out_streamer

Inter-layer serializer for the fully connected network. Captures the parallel outputs of all neurons in one layer when they fire together, then replays them one value per clock as the input stream (data plus valid) consumed by every neuron of the next layer. A one-deep pending bank absorbs a new layer result that arrives while the previous one is still streaming.

## Interface
Parameters:
- numNeurons, 30, neurons in the producing layer, which is also the stream length (2..1023).
- dataWidth, 16, width of one neuron output and one stream element.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  numNeurons*dataWidth  neuron outputs; neuron k occupies bits [k*dataWidth +: dataWidth].
- in_valid  input  numNeurons  per-neuron output valid flags.
- out_data  output  dataWidth  stream element, fed to the next layer's neuron input.
- out_valid  output  1  stream element valid, fed to the next layer's input-valid.
- out_last  output  1  high with the final element (neuron numNeurons-1) of a stream.
- busy  output  1  high while streaming or while the pending bank is full.
- overrun  output  1  sticky flag: a layer result was dropped.
- mismatch  output  1  sticky flag: in_valid was partially set.

## Operation
- Capture event: in_valid equals all ones in a cycle.
  - Nonzero but not all ones: set mismatch, ignore the data, no capture.
  - All zeros: no action.
- Storage: an active bank and a pending bank, each numNeurons x dataWidth, plus a pending_full flag.
- Element counter idx, width clog2(numNeurons).
- States:
  - IDLE: out_valid=0. On capture, load the active bank, set idx=0, go to STREAM.
  - STREAM: each cycle, out_data = active[idx] and out_valid=1; idx increments.
    - On idx=numNeurons-1 (the last cycle), out_last=1.
    - After the last cycle: if pending_full, copy pending to active, clear pending_full, set idx=0 and stay in STREAM with no gap. Otherwise go to IDLE.
- Capture while in STREAM:
  - Not the last cycle, pending empty: load pending and set pending_full.
  - Not the last cycle, pending full: drop the new data, set overrun. Pending contents are unchanged.
  - Last cycle, pending empty: load active directly; streaming continues next cycle with idx=0 and no gap.
  - Last cycle, pending full: pending moves to active and the new data loads into pending. No overrun.
- busy = (state==STREAM) | pending_full.
- overrun and mismatch are cleared only by rst.
- Data is passed through unmodified. No arithmetic and no sign handling.

## Timing
- Reset values: out_data=0, out_valid=0, out_last=0, busy=0, overrun=0, mismatch=0; state=IDLE, idx=0, pending_full=0. Bank contents are don't-care.
- All outputs are registered.
- Latency: a capture sampled at edge T gives element 0 valid in the cycle after T, held until edge T+1. Element k is valid in cycle T+1+k.
- A stream is exactly numNeurons consecutive out_valid cycles with no bubbles.
- Back-to-back layers stream with zero idle cycles between them.
- mismatch and overrun assert in the cycle after the offending input.
- rst mid-stream: out_valid drops the cycle after rst is sampled. Pending data is discarded and there is no partial-stream resume.
- No backpressure exists: the consumer must accept one element per cycle.

## Test plan
- numNeurons=4, dataWidth=16. Capture {0x0004,0x0003,0x0002,0x0001}, with neuron 0 = 0x0001, in cycle 10. Required: out_valid high in cycles 11-14, out_data 0x0001, 0x0002, 0x0003, 0x0004, out_last only in cycle 14, busy low from cycle 15.
- Second capture B in cycle 12 while streaming A. Required: A in cycles 11-14, B in cycles 15-18, busy continuously high through cycle 18, overrun=0.
- Captures B and C in cycles 12 and 13 during A. Required: C dropped, overrun=1 from cycle 14, and the stream is A then B only.
- Capture B exactly on A's last cycle (14) with pending empty. Required: B streams in cycles 15-18 with no gap and overrun stays 0.
- in_valid=4'b0101 with arbitrary data. Required: no out_valid, mismatch=1 the next cycle and held until rst.
- rst asserted during element 2 of a stream with pending full. Required: all outputs at reset values the next cycle, and the next capture streams normally from element 0.

Source files
------------

// File: rtl/layer_out_streamer.sv
// Inter-layer serializer: captures one layer's parallel neuron outputs
// and replays them one element per clock, with a one-deep pending bank.
module layer_out_streamer #(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [numNeurons*dataWidth-1:0]  in_data,
    input  logic [numNeurons-1:0]            in_valid,
    output logic [dataWidth-1:0]             out_data,
    output logic                             out_valid,
    output logic                             out_last,
    output logic                             busy,
    output logic                             overrun,
    output logic                             mismatch
);

    localparam int IW = (numNeurons > 1) ? $clog2(numNeurons) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(numNeurons - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                 state, state_n;
    logic [IW-1:0]          idx, idx_n;
    logic                   pend_full, pend_full_n;
    logic [dataWidth-1:0]   active  [numNeurons];
    logic [dataWidth-1:0]   pending [numNeurons];

    logic                   capture, partial, last;
    logic                   load_act_in, load_act_pend, load_pend;
    logic [dataWidth-1:0]   data_n;
    logic                   valid_n, last_n;
    logic                   overrun_n, mismatch_n;

    // Next-state, bank-load control and next registered output values
    always_comb begin
        capture       = &in_valid;
        partial       = (|in_valid) & ~capture;
        last          = (state == STREAM) && (idx == LAST_IDX);
        state_n       = state;
        idx_n         = idx;
        pend_full_n   = pend_full;
        load_act_in   = 1'b0;
        load_act_pend = 1'b0;
        load_pend     = 1'b0;
        data_n        = '0;
        overrun_n     = overrun;
        mismatch_n    = mismatch | partial;
        unique case (state)
            IDLE: begin
                if (capture) begin
                    load_act_in = 1'b1;
                    state_n     = STREAM;
                    idx_n       = '0;
                    data_n      = in_data[dataWidth-1:0];
                end
            end
            STREAM: begin
                if (!last) begin
                    idx_n  = idx + IW'(1);
                    data_n = active[idx_n];
                    if (capture) begin
                        if (pend_full) begin
                            overrun_n = 1'b1;
                        end else begin
                            load_pend   = 1'b1;
                            pend_full_n = 1'b1;
                        end
                    end
                end else begin
                    idx_n = '0;
                    if (pend_full) begin
                        load_act_pend = 1'b1;
                        data_n        = pending[0];
                        if (capture) begin
                            load_pend = 1'b1;
                        end else begin
                            pend_full_n = 1'b0;
                        end
                    end else if (capture) begin
                        load_act_in = 1'b1;
                        data_n      = in_data[dataWidth-1:0];
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        valid_n = (state_n == STREAM);
        last_n  = valid_n && (idx_n == LAST_IDX);
    end

    // Control state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            pend_full <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            mismatch  <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            pend_full <= pend_full_n;
            out_data  <= data_n;
            out_valid <= valid_n;
            out_last  <= last_n;
            busy      <= valid_n | pend_full_n;
            overrun   <= overrun_n;
            mismatch  <= mismatch_n;
        end
    end

    // Active and pending banks; contents need no reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < numNeurons; k++) begin
            if (load_act_in) begin
                active[k] <= in_data[k*dataWidth +: dataWidth];
            end else if (load_act_pend) begin
                active[k] <= pending[k];
            end
            if (load_pend) begin
                pending[k] <= in_data[k*dataWidth +: dataWidth];
            end
        end
    end

endmodule

// File: tb/tb_layer_out_streamer.sv
// Self-checking bench for layer_out_streamer: directed scenarios plus a
// randomized run compared against a queue-based stream model.
module tb_layer_out_streamer;

    localparam int N = 4;
    localparam int W = 16;

    logic             clk;
    logic             rst;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_last;
    logic             busy;
    logic             overrun;
    logic             mismatch;

    layer_out_streamer #(
        .numNeurons (N),
        .dataWidth  (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun),
        .mismatch  (mismatch)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: rem holds the elements still to be shown (head is
    // the one on the output now); pend holds one waiting layer or nothing.
    logic [W-1:0] rem  [$];
    logic [W-1:0] pend [$];
    logic         m_over;
    logic         m_mis;
    logic         m_after_rst;

    task automatic model_edge(input logic r, input logic [N-1:0] v,
                              input logic [N*W-1:0] d);
        logic [W-1:0] lq [$];
        logic         was;
        if (r) begin
            rem.delete();
            pend.delete();
            m_over      = 1'b0;
            m_mis       = 1'b0;
            m_after_rst = 1'b1;
            return;
        end
        m_after_rst = 1'b0;
        was = (rem.size() > 0);
        if (was) void'(rem.pop_front());
        if (v == {N{1'b1}}) begin
            for (int i = 0; i < N; i++) lq.push_back(d[i*W +: W]);
            if (!was) begin
                rem = lq;
            end else if (rem.size() > 0) begin
                if (pend.size() == 0) pend = lq;
                else m_over = 1'b1;
            end else if (pend.size() > 0) begin
                rem  = pend;
                pend = lq;
            end else begin
                rem = lq;
            end
        end else begin
            if (v != '0) m_mis = 1'b1;
            if (was && rem.size() == 0 && pend.size() > 0) begin
                rem = pend;
                pend.delete();
            end
        end
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid", W'(out_valid), W'(rem.size() > 0));
        chk("out_last",  W'(out_last),  W'(rem.size() == 1));
        chk("busy",      W'(busy),
            W'((rem.size() > 0) || (pend.size() > 0)));
        chk("overrun",   W'(overrun),   W'(m_over));
        chk("mismatch",  W'(mismatch),  W'(m_mis));
        if (rem.size() > 0) chk("out_data", out_data, rem[0]);
        else if (m_after_rst) chk("out_data_rst", out_data, '0);
    endtask

    task automatic step(input logic r, input logic [N-1:0] v,
                        input logic [N*W-1:0] d);
        rst      = r;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_edge(r, v, d);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0);
    endtask

    task automatic cap(input logic [N*W-1:0] d);
        step(1'b0, {N{1'b1}}, d);
    endtask

    task automatic do_rst();
        step(1'b1, '0, '0);
    endtask

    function automatic logic [N*W-1:0] rnd_layer();
        return {$urandom, $urandom};
    endfunction

    localparam logic [N*W-1:0] LA = 64'h0004_0003_0002_0001;
    localparam logic [N*W-1:0] LB = 64'h00B4_00B3_00B2_00B1;
    localparam logic [N*W-1:0] LC = 64'h00C4_00C3_00C2_00C1;
    localparam logic [N*W-1:0] LD = 64'h00D4_00D3_00D2_00D1;

    initial begin
        rst = 1'b1;
        in_valid = '0;
        in_data = '0;
        m_over = 1'b0;
        m_mis = 1'b0;
        m_after_rst = 1'b0;

        do_rst();
        do_rst();
        idle(2);

        // single layer
        cap(LA);
        idle(6);

        // second layer during stream: back-to-back
        cap(LA);
        idle(1);
        cap(LB);
        idle(8);

        // third layer dropped while pending full
        cap(LA);
        idle(1);
        cap(LB);
        cap(LC);
        idle(8);
        do_rst();

        // capture exactly on last element, pending empty
        cap(LA);
        idle(3);
        cap(LB);
        idle(6);

        // capture on last element with pending full
        cap(LA);
        idle(1);
        cap(LB);
        idle(1);
        cap(LC);
        idle(10);

        // partial valid sets sticky mismatch
        step(1'b0, 4'b0101, rnd_layer());
        idle(4);
        cap(LD);
        idle(5);
        do_rst();
        idle(1);

        // reset mid-stream with pending full, then restart
        cap(LA);
        cap(LB);
        idle(1);
        do_rst();
        idle(2);
        cap(LD);
        idle(6);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int rr;
            int rv;
            logic [N-1:0] v;
            rr = $urandom_range(0, 99);
            rv = $urandom_range(0, 99);
            if (rv < 55) v = '0;
            else if (rv < 95) v = {N{1'b1}};
            else v = N'($urandom_range(1, 14));
            step(rr < 2, v, rnd_layer());
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
